// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory controller.
// Consumers: dmem_ctrl (optional macro DMEM_FWD_EN), dmem_byte_merge.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

package dmem_pkg;

    // Default geometry of the data BRAM.
    localparam int DMEM_DW = `DATA_LEN;
    localparam int DMEM_MW = DMEM_DW / 8;
    localparam int DMEM_AW = 16;

    // Word address is the byte address with the lane bits stripped.
    localparam int WA_LSB = 2;

    // Byte-enable pattern of a store that needs no read-modify-write.
    localparam logic [DMEM_MW-1:0] FULL_MASK = '1;

    // Store scheduler states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RMW_RD    = 2'd1,
        RMW_MERGE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: per-byte-lane select between an old and a new word.
// Lane i takes the new byte when mask_i[i] is set, else keeps the old byte.
module dmem_byte_merge
    import dmem_pkg::*;
#(
    parameter int MW = DMEM_MW
) (
    input  logic [MW*8-1:0] old_i,
    input  logic [MW*8-1:0] new_i,
    input  logic [MW-1:0]   mask_i,
    output logic [MW*8-1:0] merged_o
);

    // Lane-wise select; unmasked lanes pass the old word through.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < MW; i++) begin
            if (mask_i[i]) begin
                merged_o[i*8 +: 8] = new_i[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store scheduler in front of the single-dual-port data BRAM.
// Optional macro DMEM_FWD_EN forwards in-flight write data to hazard loads.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW,
    parameter int MW = DW / 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 st_valid_i,
    output logic                 st_ready_o,
    input  logic [`ADDR_LEN-1:0] st_addr_i,
    input  logic [DW-1:0]        st_data_i,
    input  logic [MW-1:0]        st_mask_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [`ADDR_LEN-1:0] ld_addr_i,
    output logic                 ld_rvalid_o,
    output logic [DW-1:0]        ld_rdata_o,
    output logic                 mem_en_o,
    output logic [AW-1:0]        mem_waddr_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic [AW-1:0]        mem_raddr_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    localparam int WA_HI = AW + WA_LSB - 1;

    // Scheduler state and captured partial store.
    dmem_state_e   state_q;
    logic          st_ready_q;
    logic          alive_q;
    logic [AW-1:0] cap_addr_q;
    logic [DW-1:0] cap_data_q;
    logic [MW-1:0] cap_mask_q;

    // Write port register.
    logic          wv_q, wv_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    // Load return.
    logic          rvalid_q;

    // Decoded request view.
    logic [AW-1:0] st_word;
    logic [AW-1:0] ld_word;
    logic          st_acc;
    logic          st_full;
    logic          st_part;
    logic          ld_acc;
    logic          hit_wr;
    logic          hit_rmw;
    logic          ld_block;
    logic [DW-1:0] merged;
    logic          unused_addr_bits;

    assign st_word = st_addr_i[WA_HI:WA_LSB];
    assign ld_word = ld_addr_i[WA_HI:WA_LSB];

    // High and lane address bits carry no meaning for a word BRAM.
    assign unused_addr_bits = ^{st_addr_i[`ADDR_LEN-1:WA_HI+1],
                                st_addr_i[WA_LSB-1:0],
                                ld_addr_i[`ADDR_LEN-1:WA_HI+1],
                                ld_addr_i[WA_LSB-1:0]};

    assign st_acc  = st_valid_i && st_ready_q;
    assign st_full = (st_mask_i == FULL_MASK);
    assign st_part = st_acc && !st_full && (|st_mask_i);
    assign ld_acc  = ld_valid_i && ld_ready_o;

    // Old word arrives from the BRAM during RMW_MERGE.
    dmem_byte_merge #(
        .MW(MW)
    ) u_merge (
        .old_i   (mem_rdata_i),
        .new_i   (cap_data_q),
        .mask_i  (cap_mask_q),
        .merged_o(merged)
    );

    // Load admission: the RMW read owns the port, and same-word races stall.
    always_comb begin
        hit_wr  = wv_q && (ld_word == waddr_q);
        hit_rmw = (state_q == RMW_MERGE) && (ld_word == cap_addr_q);
`ifdef DMEM_FWD_EN
        ld_block = hit_rmw;
`else
        ld_block = hit_rmw || hit_wr;
`endif
        ld_ready_o = alive_q && (state_q != RMW_RD) && !ld_block;
    end

    // Read port: the RMW read slot wins, otherwise the load address drives.
    always_comb begin
        mem_raddr_o = ld_word;
        if (state_q == RMW_RD) begin
            mem_raddr_o = cap_addr_q;
        end
    end

    // Next write: merged RMW word, else a full store straight through.
    always_comb begin
        wv_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (state_q == RMW_MERGE) begin
            wv_d    = 1'b1;
            waddr_d = cap_addr_q;
            wdata_d = merged;
        end else if (st_acc && st_full) begin
            wv_d    = 1'b1;
            waddr_d = st_word;
            wdata_d = st_data_i;
        end
    end

    // Write port register; a reset drops any pending write.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wv_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wv_q    <= wv_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Store scheduler FSM with registered store-ready.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            st_ready_q <= 1'b0;
            alive_q    <= 1'b0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_mask_q <= '0;
        end else begin
            alive_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (st_part) begin
                        state_q    <= RMW_RD;
                        st_ready_q <= 1'b0;
                        cap_addr_q <= st_word;
                        cap_data_q <= st_data_i;
                        cap_mask_q <= st_mask_i;
                    end else begin
                        st_ready_q <= 1'b1;
                    end
                end
                RMW_RD: begin
                    state_q    <= RMW_MERGE;
                    st_ready_q <= 1'b0;
                end
                RMW_MERGE: begin
                    state_q    <= IDLE;
                    st_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    st_ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_FWD_EN
    logic          fwd_q;
    logic [DW-1:0] fwd_data_q;

    // Load return; a load racing the write takes the write data directly.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rvalid_q   <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            rvalid_q   <= ld_acc;
            fwd_q      <= ld_acc && hit_wr;
            fwd_data_q <= wdata_q;
        end
    end

    assign ld_rdata_o = fwd_q ? fwd_data_q : mem_rdata_i;
`else
    // Load return: one valid pulse per accepted load.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ld_acc;
        end
    end

    assign ld_rdata_o = mem_rdata_i;
`endif

    assign st_ready_o  = st_ready_q;
    assign ld_rvalid_o = rvalid_q;
    assign mem_en_o    = wv_q;
    assign mem_waddr_o = waddr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: transaction-level model of dmem_ctrl plus a BRAM model.
// Directed scenarios pin the model, then randomized traffic with resets.
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module tb_dmem_ctrl;

`ifdef DMEM_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_mask = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = '0;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic [15:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [15:0] mem_raddr;
    logic [31:0] mem_rdata;

    dmem_ctrl dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .st_valid_i (st_valid),
        .st_ready_o (st_ready),
        .st_addr_i  (st_addr),
        .st_data_i  (st_data),
        .st_mask_i  (st_mask),
        .ld_valid_i (ld_valid),
        .ld_ready_o (ld_ready),
        .ld_addr_i  (ld_addr),
        .ld_rvalid_o(ld_rvalid),
        .ld_rdata_o (ld_rdata),
        .mem_en_o   (mem_en),
        .mem_waddr_o(mem_waddr),
        .mem_wdata_o(mem_wdata),
        .mem_raddr_o(mem_raddr),
        .mem_rdata_i(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return {a, ~a} ^ 32'h1357_9BDF;
    endfunction

    // BRAM: registered read address, read-first on same-word write.
    logic [31:0] bram [int];

    function automatic logic [31:0] bram_rd(input logic [15:0] a);
        return bram.exists(int'(a)) ? bram[int'(a)] : init_word(a);
    endfunction

    always @(posedge clk) begin
        mem_rdata <= bram_rd(mem_raddr);
        if (mem_en) bram[int'(mem_waddr)] = mem_wdata;
    end

    // Architectural memory as the model sees committed writes.
    logic [31:0] gmem [int];

    function automatic logic [31:0] gm_rd(input logic [15:0] a);
        return gmem.exists(int'(a)) ? gmem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0]  m);
        logic [31:0] bm;
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (n & bm) | (o & ~bm);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model timeline, indexed by clock period.
    int          p  = 0;
    int          rl = -100;
    int          rT = -100;
    logic [15:0] rw = '0;
    logic [31:0] rdat = '0;
    logic [3:0]  rmask = '0;
    int          fp = -100;
    logic [15:0] fw = '0;
    logic [31:0] fd = '0;
    int          lp = -100;
    logic [31:0] lexp = '0;

    logic        obs_st, obs_ld, obs_rv, obs_en;
    logic [15:0] obs_wa, obs_ra;
    logic [31:0] obs_wd, obs_rd;

    // One period: drive, check every output against the model, advance.
    task automatic step(input logic rn, input logic sv,
                        input logic [31:0] sa, input logic [31:0] sd,
                        input logic [3:0] sm, input logic lv,
                        input logic [31:0] la);
        logic        alive, e_wen, e_st, e_ld, e_rv;
        logic [15:0] e_ww, e_ra, lw;
        logic [31:0] e_wd;
        @(negedge clk);
        reset_n  = rn;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        st_mask  = sm;
        ld_valid = lv;
        ld_addr  = la;
        #1;
        alive = (p >= rl + 2);
        e_wen = 1'b0;
        e_ww  = '0;
        e_wd  = '0;
        if (p == rT + 3) begin
            e_wen = 1'b1;
            e_ww  = rw;
            e_wd  = merge(gm_rd(rw), rdat, rmask);
        end else if (p == fp) begin
            e_wen = 1'b1;
            e_ww  = fw;
            e_wd  = fd;
        end
        lw   = la[17:2];
        e_st = alive && (p != rT + 1) && (p != rT + 2);
        e_ld = alive && (p != rT + 1)
            && !((p == rT + 2) && (lw == rw))
            && !(e_wen && (lw == e_ww) && !FWD);
        e_ra = (p == rT + 1) ? rw : lw;
        e_rv = (p == lp + 1);
        if (p >= 1) begin
            chk("st_ready", 32'(st_ready), 32'(e_st));
            chk("ld_ready", 32'(ld_ready), 32'(e_ld));
            chk("mem_raddr", 32'(mem_raddr), 32'(e_ra));
            chk("mem_en", 32'(mem_en), 32'(e_wen));
            if (e_wen) begin
                chk("mem_waddr", 32'(mem_waddr), 32'(e_ww));
                chk("mem_wdata", mem_wdata, e_wd);
            end
            chk("ld_rvalid", 32'(ld_rvalid), 32'(e_rv));
            if (e_rv) chk("ld_rdata", ld_rdata, lexp);
        end
        obs_st = st_ready;
        obs_ld = ld_ready;
        obs_rv = ld_rvalid;
        obs_en = mem_en;
        obs_wa = mem_waddr;
        obs_wd = mem_wdata;
        obs_ra = mem_raddr;
        obs_rd = ld_rdata;
        if (rn && lv && e_ld) begin
            lp = p;
            lexp = (FWD && e_wen && (lw == e_ww)) ? e_wd : gm_rd(lw);
        end
        if (e_wen) gmem[int'(e_ww)] = e_wd;
        if (rn && sv && e_st) begin
            if (sm == 4'hF) begin
                fp = p + 1;
                fw = sa[17:2];
                fd = sd;
            end else if (sm != 4'h0) begin
                rT = p;
                rw = sa[17:2];
                rdat = sd;
                rmask = sm;
            end
        end
        if (!rn) begin
            rl = p;
            rT = -100;
            fp = -100;
            lp = -100;
        end
        p++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic load(input logic [31:0] a);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, a);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        step(1'b1, 1'b1, a, d, m, 1'b0, '0);
    endtask

    // Keep presenting a load until accepted (bounded), then check its data.
    task automatic load_until(input logic [31:0] a, input logic [31:0] want,
                              input string nm);
        int k = 0;
        while (!obs_ld && k < 4) begin
            load(a);
            k++;
        end
        chk({nm, "_accept"}, 32'(obs_ld), 32'd1);
        idle(1);
        chk({nm, "_rvalid"}, 32'(obs_rv), 32'd1);
        chk({nm, "_rdata"}, obs_rd, want);
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        chk("rst_st_ready", 32'(obs_st), 32'd0);
        chk("rst_ld_ready", 32'(obs_ld), 32'd0);
        chk("rst_rvalid", 32'(obs_rv), 32'd0);
        chk("rst_mem_en", 32'(obs_en), 32'd0);
        idle(1);
        chk("post_rst_st0", 32'(obs_st), 32'd0);
        idle(1);
        chk("post_rst_st1", 32'(obs_st), 32'd1);
        chk("post_rst_ld1", 32'(obs_ld), 32'd1);

        store(32'h40, 32'hDEAD_BEEF, 4'hF);
        idle(1);
        chk("full_en", 32'(obs_en), 32'd1);
        chk("full_waddr", 32'(obs_wa), 32'h10);
        chk("full_wdata", obs_wd, 32'hDEAD_BEEF);
        idle(1);
        load(32'h40);
        idle(1);
        chk("full_ld_rv", 32'(obs_rv), 32'd1);
        chk("full_ld_rd", obs_rd, 32'hDEAD_BEEF);

        store(32'h40, 32'h1122_3344, 4'hF);
        idle(1);
        store(32'h40, 32'h0000_AA00, 4'b0010);
        load(32'h80);
        chk("rmw_rd_ldrdy", 32'(obs_ld), 32'd0);
        chk("rmw_rd_raddr", 32'(obs_ra), 32'h10);
        chk("rmw_rd_strdy", 32'(obs_st), 32'd0);
        load(32'h80);
        chk("rmw_mg_ldrdy", 32'(obs_ld), 32'd1);
        chk("rmw_mg_strdy", 32'(obs_st), 32'd0);
        load(32'h40);
        chk("rmw_wr_en", 32'(obs_en), 32'd1);
        chk("rmw_wr_data", obs_wd, 32'h1122_AA44);
        chk("rmw_wr_strdy", 32'(obs_st), 32'd1);
        chk("rmw_ld80_rv", 32'(obs_rv), 32'd1);
        chk("rmw_ld40_rdy", 32'(obs_ld), 32'(FWD));
        load_until(32'h40, 32'h1122_AA44, "rmw_ld40");

        store(32'h40, 32'h0000_0005, 4'hF);
        load(32'h40);
        chk("haz_ldrdy", 32'(obs_ld), 32'(FWD));
        load_until(32'h40, 32'h0000_0005, "haz");

        store(32'h40, 32'h0000_00FF, 4'b0001);
        idle(1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
        idle(1);
        chk("rrmw_en", 32'(obs_en), 32'd0);
        chk("rrmw_st", 32'(obs_st), 32'd0);
        chk("rrmw_ld", 32'(obs_ld), 32'd0);
        chk("rrmw_rv", 32'(obs_rv), 32'd0);
        idle(1);
        chk("rrmw_st_back", 32'(obs_st), 32'd1);
        load(32'h40);
        idle(1);
        chk("rrmw_keep", obs_rd, 32'h0000_0005);

        for (int i = 0; i < 8; i++) begin
            store(32'h100 + 32'(i) * 4, 32'(i) + 32'hA0, 4'hF);
            chk("stream_st", 32'(obs_st), 32'd1);
            if (i > 0) begin
                chk("stream_en", 32'(obs_en), 32'd1);
                chk("stream_wa", 32'(obs_wa), 32'h40 + 32'(i) - 1);
            end
        end
        store(32'h200, 32'hFFFF_FFFF, 4'h0);
        chk("stream_last_en", 32'(obs_en), 32'd1);
        chk("stream_last_wa", 32'(obs_wa), 32'h47);
        idle(1);
        chk("mask0_no_en", 32'(obs_en), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            logic        rn, sv, lv;
            logic [3:0]  sm;
            logic [31:0] sa, la;
            int          r;
            rn = ($urandom_range(0, 299) != 0);
            sv = 1'($urandom_range(0, 1));
            lv = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sm = (r < 4) ? 4'hF
               : (r == 4) ? 4'h0
               : 4'($urandom_range(1, 14));
            sa = ($urandom & 32'hFFFC_0003)
               | (32'($urandom_range(0, 15)) << 2);
            la = ($urandom & 32'hFFFC_0003)
               | (32'($urandom_range(0, 15)) << 2);
            step(rn, sv, sa, $urandom, sm, lv, la);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
